dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single data memory (DMEM) port between the CPU load/store path and a secondary debug/DMA requester used to preload or dump memory. It sits between the CPU bus and DMEM's address, write-data and write-enable inputs, in front of the sub-word cut logic. The CPU has priority. A starvation counter can force occasional debug grants, stalling the CPU for one cycle each time.

## Interface
- DMEM_BASE, 32'h10010000, byte address mapped to DMEM word 0
- MAX_WAIT, 8, consecutive blocked debug cycles before a forced debug grant (legal range 1..255)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- cpu_req  input  1  CPU memory access this cycle
- cpu_we  input  1  CPU write (1) / read (0)
- cpu_addr  input  32  CPU byte address
- cpu_wdata  input  32  CPU write word (already merged by sub-word logic)
- cpu_rdata  output  32  CPU read word
- cpu_stall  output  1  CPU access not performed this cycle; CPU must hold the request
- dbg_req  input  1  debug request; held stable until dbg_gnt
- dbg_we  input  1  debug write (1) / read (0)
- dbg_addr  input  32  debug byte address
- dbg_wdata  input  32  debug write word
- dbg_gnt  output  1  debug access performed this cycle
- dbg_rvalid  output  1  registered debug read data valid
- dbg_rdata  output  32  registered debug read data
- mem_wena  output  1  DMEM write enable
- mem_addr  output  32  DMEM word index = (granted addr − DMEM_BASE) >> 2
- mem_wdata  output  32  DMEM write data
- mem_rdata  input  32  DMEM asynchronous read data
- stall_cnt  output  16  saturating count of cycles with cpu_stall=1

## Operation
- Owner selection is combinational each cycle from the requests and registered wait_cnt (8-bit).
- Only cpu_req: CPU owns the port; cpu_stall=0, dbg_gnt=0.
- Only dbg_req: debug owns the port; dbg_gnt=1.
- Both: CPU owns the port, except when wait_cnt == MAX_WAIT, in which case debug owns it, dbg_gnt=1 and cpu_stall=1.
- Neither: mem_wena=0; mem_addr and mem_wdata follow the CPU inputs.
- The owner's address maps to mem_addr via 32-bit subtraction. Bits [1:0] are dropped. An address below DMEM_BASE wraps; no error is flagged.
- mem_wena = owner's we AND owner's req.
- cpu_rdata = mem_rdata at all times.
- wait_cnt:
  - Increments when dbg_req=1 and dbg_gnt=0.
  - Clears when dbg_gnt=1 or dbg_req=0.
  - Never exceeds MAX_WAIT.
- Debug read grant (dbg_we=0): dbg_rdata <= mem_rdata and dbg_rvalid <= 1 on the next edge. Otherwise dbg_rvalid <= 0, and dbg_rdata holds its value.
- stall_cnt increments on each cpu_stall cycle and saturates at 16'hFFFF.

## Timing
- Reset values: wait_cnt=0, dbg_rvalid=0, dbg_rdata=0, stall_cnt=0. While rst=1, dbg_gnt=0, cpu_stall=0 and mem_wena=0 are forced.
- Reset mid-operation: an asynchronous rst clears dbg_rvalid immediately, and any pending forced grant is lost.
- CPU access latency:
  - Read data is valid in the same cycle (combinational through DMEM).
  - A write commits at the rising edge ending the access cycle.
- Debug access latency:
  - A write commits at the edge ending the dbg_gnt cycle.
  - Read data appears with dbg_rvalid exactly 1 cycle after dbg_gnt, for 1 cycle.
- Back-to-back debug grants are allowed (debug only, no CPU request). dbg_rvalid then stays high, with new data each cycle.
- Forced grant cadence under continuous contention: 1 debug cycle per MAX_WAIT+1 cycles.

## Configuration
- DMEM_ARB_FAIRNESS_EN defined: wait_cnt, the forced debug grant and stall_cnt behave as above.
- DMEM_ARB_FAIRNESS_EN undefined: strict CPU priority.
  - Debug is granted only when cpu_req=0.
  - cpu_stall is constant 0.
  - wait_cnt and stall_cnt are removed; stall_cnt reads 0.

## Test plan
- Reset: assert rst mid-cycle with dbg_rvalid=1 → dbg_rvalid, dbg_rdata and stall_cnt read 0 immediately; mem_wena=0.
- CPU write: cpu_req=1, cpu_we=1, cpu_addr=32'h10010008, cpu_wdata=32'hDEADBEEF → mem_addr=2, mem_wena=1, cpu_stall=0; the word reads back 32'hDEADBEEF the next cycle.
- Debug read: DMEM word 1 = 32'h12345678; dbg_req=1, dbg_we=0, dbg_addr=32'h10010004, no CPU request → dbg_gnt=1 in cycle N; dbg_rvalid=1 and dbg_rdata=32'h12345678 in cycle N+1.
- Contention with the macro defined, MAX_WAIT=8, both requests held → CPU served in cycles 0–7; cycle 8 has dbg_gnt=1 and cpu_stall=1; wait_cnt returns to 0; stall_cnt=1.
- Contention with the macro undefined → dbg_gnt stays 0 for 100 cycles; it rises in the first cycle after cpu_req drops.
- Saturation: force continuous contention with MAX_WAIT=1 for over 131072 cycles → stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/dmem_arbiter.sv
// DMEM port arbiter: CPU load/store path vs. debug/DMA requester, CPU first.
// Define DMEM_ARB_FAIRNESS_EN to enable the starvation counter and forced debug grants.
module dmem_arbiter #(
   parameter logic [31:0] DMEM_BASE = 32'h10010000,
   parameter int          MAX_WAIT  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic        mem_wena,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [15:0] stall_cnt
);

   logic        dbg_own;
   logic [31:0] sel_addr;
   logic [31:0] off_addr;

`ifdef DMEM_ARB_FAIRNESS_EN
   localparam logic [7:0] WAIT_LIM = MAX_WAIT[7:0];

   logic [7:0] wait_cnt;

   assign dbg_own   = dbg_req && (!cpu_req || (wait_cnt == WAIT_LIM));
   assign cpu_stall = !rst && cpu_req && dbg_own;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= 8'd0;
      end else if (!dbg_req || dbg_gnt) begin
         wait_cnt <= 8'd0;
      end else if (wait_cnt < WAIT_LIM) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= 16'd0;
      end else if (cpu_stall && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`else
   // Strict priority: debug only ever gets an idle port, so the CPU never stalls.
   assign dbg_own   = dbg_req && !cpu_req;
   assign cpu_stall = 1'b0;
   assign stall_cnt = 16'd0;
`endif

   assign dbg_gnt   = !rst && dbg_own;
   assign sel_addr  = dbg_own ? dbg_addr : cpu_addr;
   assign off_addr  = sel_addr - DMEM_BASE;
   assign mem_addr  = {2'b00, off_addr[31:2]};
   assign mem_wdata = dbg_own ? dbg_wdata : cpu_wdata;
   assign mem_wena  = !rst && (dbg_own ? dbg_we : (cpu_req && cpu_we));
   assign cpu_rdata = mem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= 32'd0;
      end else begin
         dbg_rvalid <= dbg_gnt && !dbg_we;
         if (dbg_gnt && !dbg_we) begin
            dbg_rdata <= mem_rdata;
         end
      end
   end

endmodule
